// File: rtl/fcmp_stage_pkg.sv
// Shared FPU compare definitions: op encoding, float32 field layout and the
// sign-magnitude "greater or equal" rule used by the compare core.
package fpu_pkg;

  typedef enum logic [1:0] {
    FCMP_EQ  = 2'b00,
    FCMP_LT  = 2'b01,
    FCMP_LE  = 2'b10,
    FCMP_RSV = 2'b11
  } fcmp_op_t;

  localparam int FP_W     = 32;
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int EXP_W    = EXP_MSB - EXP_LSB + 1;
  localparam int MANT_W   = 23;

  // Raw sign-magnitude ordering; NaN and denormals are deliberately not special-cased.
  function automatic logic fp_ge(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
    logic              sa;
    logic              sb;
    logic [EXP_W-1:0]  ea;
    logic [EXP_W-1:0]  eb;
    logic [MANT_W-1:0] ma;
    logic [MANT_W-1:0] mb;
    logic              ge;
    sa = a[SIGN_BIT];
    sb = b[SIGN_BIT];
    ea = a[EXP_MSB:EXP_LSB];
    eb = b[EXP_MSB:EXP_LSB];
    ma = a[MANT_W-1:0];
    mb = b[MANT_W-1:0];
    case ({sa, sb})
      2'b00:   ge = (ea == eb) ? (ma >= mb) : (ea >= eb);
      2'b01:   ge = 1'b1;
      2'b10:   ge = 1'b0;
      default: ge = (ea == eb) ? (ma <= mb) : (ea <= eb);
    endcase
    return ge;
  endfunction

endpackage

// File: rtl/fcmp_stage_core.sv
// Combinational float32 compare: FEQ / FLT / FLE, reserved op yields 0.
module fcmp_core
  import fpu_pkg::*;
(
  input  logic [FP_W-1:0] x1_i,
  input  logic [FP_W-1:0] x2_i,
  input  fcmp_op_t        op_i,
  output logic            cmp_o
);

  logic eq;
  logic ge;

  always_comb begin
    eq = (x1_i == x2_i);
    ge = fp_ge(x1_i, x2_i);
    case (op_i)
      FCMP_EQ: cmp_o = eq;
      FCMP_LT: cmp_o = !ge;
      FCMP_LE: cmp_o = !ge || eq;
      default: cmp_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/fcmp_stage.sv
// Two-stage FPU compare execution stage: S1 captures the op, S2 holds the
// registered result for writeback. Flushable, full throughput.
module fcmp_stage
  import fpu_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_x1,
  input  logic [31:0]      in_x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag
);

  // Handshake: a transfer happens on a side when valid && ready at posedge;
  // ready never depends on valid of the same side, and out_* hold while stalled.
  logic             s1_valid_q, s1_valid_d;
  fcmp_op_t         s1_op_q, s1_op_d;
  logic [31:0]      s1_x1_q, s1_x1_d;
  logic [31:0]      s1_x2_q, s1_x2_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s2_valid_q, s2_valid_d;
  logic             s2_cmp_q, s2_cmp_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic             s1_advance;
  logic             core_cmp;

  fcmp_core u_core (
    .x1_i  (s1_x1_q),
    .x2_i  (s1_x2_q),
    .op_i  (s1_op_q),
    .cmp_o (core_cmp)
  );

  always_comb begin
    s1_advance = !s2_valid_q || out_ready;
    in_ready   = !s1_valid_q || s1_advance;

    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_x1_d    = s1_x1_q;
    s1_x2_d    = s1_x2_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    s2_cmp_d   = s2_cmp_q;
    s2_tag_d   = s2_tag_q;

    // A flush drops everything in flight, including an op presented this cycle.
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s1_advance) begin
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          s2_cmp_d = core_cmp;
          s2_tag_d = s1_tag_q;
        end
      end
      if (in_ready) begin
        s1_valid_d = in_valid;
        if (in_valid) begin
          s1_op_d  = fcmp_op_t'(in_op);
          s1_x1_d  = in_x1;
          s1_x2_d  = in_x2;
          s1_tag_d = in_tag;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= FCMP_EQ;
      s1_x1_q    <= '0;
      s1_x2_q    <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_cmp_q   <= 1'b0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_x1_q    <= s1_x1_d;
      s1_x2_q    <= s1_x2_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_cmp_q   <= s2_cmp_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = {31'b0, s2_cmp_q};
  assign out_tag   = s2_tag_q;

endmodule

// File: tb/tb_fcmp_stage.sv
// Bench for fcmp_stage: directed corner cases plus randomized traffic with
// random backpressure and flushes, checked against an ordering-key model.
module tb_fcmp_stage;

  localparam int TAG_W = 5;
  localparam int W     = TAG_W + 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_op = 2'b00;
  logic [31:0]      in_x1 = '0;
  logic [31:0]      in_x2 = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;

  int          n_vec = 0;
  int          n_fail = 0;
  int          n_out = 0;
  logic [W-1:0] exp_q[$];
  logic         stall_pend = 1'b0;
  logic [W-1:0] prev_out = '0;
  logic         saw_block = 1'b0;
  logic         bg_run = 1'b0;

  fcmp_stage #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_x1     (in_x1),
    .in_x2     (in_x2),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, obs, expv);
    end
  endtask

  // Reference: map each float to a signed ordering key; -0 sorts just below +0.
  function automatic logic ref_cmp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ka;
    longint kb;
    logic   ge;
    logic   eq;
    ka = {33'b0, a[30:0]};
    kb = {33'b0, b[30:0]};
    if (a[31]) ka = -ka - 1;
    if (b[31]) kb = -kb - 1;
    ge = (ka >= kb);
    eq = (a == b);
    case (op)
      2'd0:    return eq;
      2'd1:    return !ge;
      2'd2:    return !ge || eq;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] specials [10];
    specials = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000, 32'h40000000,
                 32'hC0000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h00000001};
    case ($urandom_range(0, 2))
      0:       return specials[$urandom_range(0, 9)];
      1:       return {$urandom_range(0, 1) == 1, 8'd127 + 8'($urandom_range(0, 3)), 23'($urandom_range(0, 7) << 20)};
      default: return $urandom;
    endcase
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (stall_pend) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", {out_tag, out_data}, prev_out);
    end
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) check("unexpected_out", {out_tag, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      else check("result", {out_tag, out_data}, exp_q.pop_front());
    end
    if (flush || rst) exp_q.delete();
    else if (in_valid && in_ready) exp_q.push_back({in_tag, 31'b0, ref_cmp(in_op, in_x1, in_x2)});
    if (in_valid && !in_ready) saw_block = 1'b1;
    stall_pend = out_valid && !out_ready && !flush && !rst;
    prev_out   = {out_tag, out_data};
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic drive_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] t);
    int k;
    in_valid = 1'b1;
    in_op    = op;
    in_x1    = a;
    in_x2    = b;
    in_tag   = t;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      k++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_dir(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic e);
    int k;
    drive_op(op, a, b, 5'($urandom_range(0, 31)));
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 20) begin
      k++;
      @(negedge clk);
    end
    check(name, out_data, {31'b0, e});
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n0;
    logic [31:0] a;
    logic [31:0] b;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", out_tag, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // 1: latency and basic FLT
    in_valid = 1'b1; in_op = 2'd1; in_x1 = 32'h3F800000; in_x2 = 32'h40000000; in_tag = 5'h13;
    @(negedge clk);
    check("t1_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("t1_lat1_idle", out_valid, 0);
    @(negedge clk);
    check("t1_lat2_valid", out_valid, 1);
    check("t1_data", out_data, 1);
    check("t1_tag", out_tag, 5'h13);
    @(posedge clk);
    #1;

    // 2/3: signed zeros and negative ordering
    run_dir("t2_feq_zeros", 2'd0, 32'h00000000, 32'h80000000, 1'b0);
    run_dir("t2_fle_n0_p0", 2'd2, 32'h80000000, 32'h00000000, 1'b1);
    run_dir("t2_fle_p0_n0", 2'd2, 32'h00000000, 32'h80000000, 1'b0);
    run_dir("t2_flt_n0_p0", 2'd1, 32'h80000000, 32'h00000000, 1'b1);
    run_dir("t3_fle_m2_m1", 2'd2, 32'hC0000000, 32'hBF800000, 1'b1);
    run_dir("t3_flt_m1_m2", 2'd1, 32'hBF800000, 32'hC0000000, 1'b0);
    run_dir("t3_flt_m15_m1", 2'd1, 32'hBFC00000, 32'hBF800000, 1'b1);
    run_dir("t3_feq_nan", 2'd0, 32'h7FC00000, 32'h7FC00000, 1'b1);
    run_dir("rsv_op", 2'd3, 32'h3F800000, 32'h40000000, 1'b0);
    drain();

    // 4: back-to-back stream with a backpressure window
    n0 = n_out;
    saw_block = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) drive_op(2'($urandom_range(0, 3)), rand_fp(), rand_fp(), 5'(i));
      end
      begin
        for (int k = 0; k < 10; k++) begin
          @(posedge clk);
          #1;
          out_ready = !(k >= 2 && k <= 5);
        end
      end
    join
    out_ready = 1'b1;
    drain();
    check("t4_in_ready_dropped", saw_block, 1);
    check("t4_out_count", n_out - n0, 8);

    // 5: flush with two ops in flight and a third presented
    out_ready = 1'b0;
    n0 = n_out;
    drive_op(2'd1, 32'h3F800000, 32'h40000000, 5'd1);
    drive_op(2'd0, 32'h3F800000, 32'h3F800000, 5'd2);
    in_valid = 1'b1; in_op = 2'd2; in_x1 = 32'h0; in_x2 = 32'h0; in_tag = 5'd3;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("t5_out_valid_killed", out_valid, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("t5_still_empty", out_valid, 0);
    check("t5_none_emitted", n_out - n0, 0);
    @(posedge clk);
    #1;

    // 6: reset with a full, stalled pipe
    out_ready = 1'b0;
    drive_op(2'd1, 32'h3F800000, 32'h40000000, 5'd9);
    drive_op(2'd1, 32'h40000000, 32'h3F800000, 5'd10);
    @(negedge clk);
    check("t6_full_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_out_data", out_data, 0);
    check("t6_rst_out_tag", out_tag, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    run_dir("t6_after_rst", 2'd1, 32'hBFC00000, 32'hBF800000, 1'b1);
    drain();

    // Random traffic with random backpressure and flushes
    bg_run = 1'b1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          a = rand_fp();
          case ($urandom_range(0, 3))
            0:       b = a;
            1:       b = a ^ 32'h80000000;
            default: b = rand_fp();
          endcase
          drive_op(2'($urandom_range(0, 3)), a, b, 5'($urandom_range(0, 31)));
        end
        bg_run = 1'b0;
      end
      begin
        while (bg_run) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
          flush     = ($urandom_range(0, 39) == 0);
        end
        flush = 1'b0;
        out_ready = 1'b1;
      end
    join
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
